// File: rtl/uart_rx_ext.sv
// UART receiver with majority-vote sampling, optional parity,
// one/two stop bits and a single-entry output register with overrun.
module uart_rx_ext #(
  parameter int DATA_WIDTH  = 8,
  parameter int OS_RATE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  rx_busy
);

  localparam int CW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int M  = OS_RATE / 2;

  localparam logic [CW-1:0] C_MAX = CW'(OS_RATE - 1);
  localparam logic [CW-1:0] C_LO  = CW'(M - 1);
  localparam logic [CW-1:0] C_MID = CW'(M);
  localparam logic [CW-1:0] C_HI  = CW'(M + 1);
  localparam logic [BW-1:0] I_END = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] I_ONE = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           idx_q, idx_d;
  logic [1:0]              vs_q, vs_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    pen_q, pen_d;
  logic                    podd_q, podd_d;
  logic                    two_q, two_d;
  logic                    pacc_q, pacc_d;
  logic                    facc_q, facc_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    dv_q, dv_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;

  logic rx_s, vote, at_hi, wrap, complete, last_stop;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign at_hi     = bclk && (cnt_q == C_HI);
  assign wrap      = bclk && (cnt_q == C_MAX);
  assign vote      = (vs_q[0] & vs_q[1]) | (vs_q[0] & rx_s) | (vs_q[1] & rx_s);
  assign last_stop = (idx_q == {{(BW-1){1'b0}}, two_q});

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d   = rx_s;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    vs_d     = vs_q;
    shift_d  = shift_q;
    pen_d    = pen_q;
    podd_d   = podd_q;
    two_d    = two_q;
    pacc_d   = pacc_q;
    facc_d   = facc_q;
    complete = 1'b0;

    if (state_q != S_IDLE && bclk) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (cnt_q == C_LO)  vs_d[0] = rx_s;
      if (cnt_q == C_MID) vs_d[1] = rx_s;
    end

    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          pen_d   = parity_en;
          podd_d  = parity_odd;
          two_d   = two_stop;
          pacc_d  = 1'b0;
          facc_d  = 1'b0;
        end
      end
      S_START: begin
        // A high vote means the edge was noise, not a start bit
        if (at_hi && vote) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_hi) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          idx_d   = idx_q + I_ONE;
        end
        if (wrap && idx_q == I_END) begin
          idx_d   = '0;
          state_d = pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_hi) pacc_d = ^shift_q ^ vote ^ podd_q;
        if (wrap)  state_d = S_STOP;
      end
      S_STOP: begin
        if (at_hi) begin
          facc_d = facc_q | ~vote;
          if (last_stop) begin
            complete = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end else begin
            idx_d = idx_q + I_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = 1'b0;
    if (dv_q && dout_ready) dv_d = 1'b0;
    if (complete) begin
      if (!dv_q || dout_ready) begin
        dout_d = shift_q;
        perr_d = pacc_q;
        ferr_d = facc_q | ~vote;
        dv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      vs_q    <= '0;
      shift_q <= '0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      two_q   <= 1'b0;
      pacc_q  <= 1'b0;
      facc_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vs_q    <= vs_d;
      shift_q <= shift_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      two_q   <= two_d;
      pacc_q  <= pacc_d;
      facc_q  <= facc_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: bclk every clk, 16 clks per bit.
module tb_uart_rx_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk;
  logic       rx;
  logic       parity_en, parity_odd, two_stop;
  logic [7:0] dout;
  logic       dout_valid, dout_ready;
  logic       parity_err, frame_err, overrun, rx_busy;

  int nvec = 0;
  int nerr = 0;
  int nwords = 0;
  int novr = 0;
  int w0, o0;

  always #5 clk = ~clk;

  uart_rx_ext dut (
    .clk(clk), .rst(rst), .bclk(bclk), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always @(posedge clk) begin
    if (dout_valid && dout_ready) nwords++;
    if (overrun) novr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int glitch_at);
    for (int i = 0; i < 16; i++) begin
      rx = (i == glitch_at) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit with_par, input logic pbit,
                            input bit with_stop2, input logic stop2,
                            input int glitch_bit);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++)
      send_bit(d[i], (i == glitch_bit) ? 9 : -1);
    if (with_par) send_bit(pbit, -1);
    send_bit(1'b1, -1);
    if (with_stop2) send_bit(stop2, -1);
    rx = 1'b1;
  endtask

  task automatic accept(input string tag);
    dout_ready = 1'b1;
    clks(1);
    dout_ready = 1'b0;
    @(negedge clk);
    check(tag, dout_valid, 1'b0);
    clks(1);
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b1; rx = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    dout_ready = 1'b0;
    clks(3);
    @(negedge clk);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    clks(1);
    rst = 1'b0;
    clks(4);

    send_frame(8'hA5, 0, 1'b0, 0, 1'b1, -1);
    clks(32);
    @(negedge clk);
    check("a5_valid", dout_valid, 1'b1);
    check("a5_dout", dout, 8'hA5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);
    check("a5_busy", rx_busy, 1'b0);
    clks(1);
    accept("a5_clear");
    check("a5_words", nwords, 1);

    parity_en = 1'b1; parity_odd = 1'b1;
    send_frame(8'h03, 1, 1'b0, 0, 1'b1, -1);
    clks(4);
    @(negedge clk);
    check("par0_dout", dout, 8'h03);
    check("par0_perr", parity_err, 1'b1);
    check("par0_ferr", frame_err, 1'b0);
    clks(1);
    accept("par0_clear");
    send_frame(8'h03, 1, 1'b1, 0, 1'b1, -1);
    clks(4);
    @(negedge clk);
    check("par1_valid", dout_valid, 1'b1);
    check("par1_perr", parity_err, 1'b0);
    clks(1);
    accept("par1_clear");
    parity_en = 1'b0; parity_odd = 1'b0;

    w0 = nwords;
    rx = 1'b0;
    clks(4);
    @(negedge clk);
    check("fs_busy_hi", rx_busy, 1'b1);
    clks(1);
    rx = 1'b1;
    clks(20);
    @(negedge clk);
    check("fs_busy_lo", rx_busy, 1'b0);
    check("fs_valid", dout_valid, 1'b0);
    check("fs_words", nwords, w0);
    clks(1);

    two_stop = 1'b1;
    send_frame(8'h5A, 0, 1'b0, 1, 1'b0, -1);
    clks(4);
    @(negedge clk);
    check("fe_valid", dout_valid, 1'b1);
    check("fe_dout", dout, 8'h5A);
    check("fe_ferr", frame_err, 1'b1);
    check("fe_perr", parity_err, 1'b0);
    clks(1);
    accept("fe_clear");
    two_stop = 1'b0;

    w0 = nwords; o0 = novr;
    send_frame(8'h11, 0, 1'b0, 0, 1'b1, -1);
    send_frame(8'h22, 0, 1'b0, 0, 1'b1, -1);
    clks(8);
    @(negedge clk);
    check("ov_valid", dout_valid, 1'b1);
    check("ov_dout", dout, 8'h11);
    check("ov_pulses", novr - o0, 1);
    clks(1);
    accept("ov_clear");
    check("ov_words", nwords - w0, 1);

    send_frame(8'hFF, 0, 1'b0, 0, 1'b1, 3);
    clks(4);
    @(negedge clk);
    check("gl_valid", dout_valid, 1'b1);
    check("gl_dout", dout, 8'hFF);
    check("gl_ferr", frame_err, 1'b0);
    clks(1);
    accept("gl_clear");

    w0 = nwords;
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
    @(negedge clk);
    check("mr_busy_hi", rx_busy, 1'b1);
    clks(1);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    @(negedge clk);
    check("mr_busy_rst", rx_busy, 1'b0);
    clks(200);
    @(negedge clk);
    check("mr_valid", dout_valid, 1'b0);
    check("mr_busy", rx_busy, 1'b0);
    check("mr_words", nwords, w0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OS_RATE, default 16, bclk ticks per bit (even, legal 8..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, rx synchroniser depth (legal 2..3).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port bclk  input  1  oversample tick, 1-clk pulse, OS_RATE per bit.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port parity_en  input  1  1 = a parity bit follows the data bits.
REQ-009 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even.
REQ-010 SHALL have port two_stop  input  1  1 = two stop bits checked.
REQ-011 SHALL have port dout  output  DATA_WIDTH  received word, LSB = first data bit.
REQ-012 SHALL have port dout_valid  output  1  dout and error flags valid.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts word when high with dout_valid.
REQ-014 SHALL have port parity_err  output  1  parity mismatch for the word held on dout.
REQ-015 SHALL have port frame_err  output  1  stop bit sampled low for the word held on dout.
REQ-016 SHALL have port overrun  output  1  1-clk pulse: completed frame dropped.
REQ-017 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-018 rx SHALL pass through SYNC_STAGES flops (reset value 1) before use; rx_s = synchronised value.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START SHALL occur only on a falling edge of rx_s (previous 1, current 0); a low line does not retrigger.
REQ-021 On entry to START, parity_en, parity_odd and two_stop SHALL be latched; mid-frame input changes are ignored.
REQ-022 Bit counter cnt SHALL reset to 0 on START entry; on each bclk tick it increments, wrapping OS_RATE-1 -> 0, and the wrap advances to the next bit.
REQ-023 Each bit value SHALL be the majority of rx_s sampled on the ticks where cnt = M-1, M, M+1 (M = OS_RATE/2); the decision is made on the M+1 tick.
REQ-024 START with voted value 1 SHALL be a false start: return to IDLE, no output, no error.
REQ-025 DATA SHALL collect DATA_WIDTH bits LSB-first, then go to PARITY if parity_en, else STOP.
REQ-026 parity_err SHALL be XOR(data, parity bit) = 1 for even, = 0 for odd; 0 when parity disabled.
REQ-027 frame_err SHALL be set if any checked stop bit votes 0 (1 or 2 stop bits per two_stop).
REQ-028 The frame SHALL complete on the vote tick of the last stop bit, returning to IDLE next clk, enabling back-to-back frames.
REQ-029 On completion, if dout_valid = 0 or dout_ready = 1 in that cycle, dout/parity_err/frame_err SHALL load and dout_valid = 1 on the next clk.
REQ-030 On completion with dout_valid = 1 and dout_ready = 0, the new frame SHALL be discarded, held word unchanged, overrun pulses 1 clk.
REQ-031 dout_valid SHALL clear on the clk after dout_valid & dout_ready unless a simultaneous completion reloads it (REQ-029).
REQ-032 dout, parity_err, frame_err SHALL stay stable while dout_valid = 1 and dout_ready = 0.
REQ-033 bclk ticks SHALL be ignored in IDLE; no state advances without a bclk tick outside IDLE.

Reset
REQ-034 rst SHALL set state IDLE, cnt 0, bit index 0, dout 0, dout_valid 0, parity_err 0, frame_err 0, overrun 0, rx_busy 0, sync flops 1.
REQ-035 rst during a frame SHALL abort it with no dout_valid; after reset the receiver waits for a new falling edge.

Verification
REQ-036 Defaults, bclk every clk, send 0xA5 8N1 -> dout = 0xA5, dout_valid = 1, both errors 0, one word.
REQ-037 parity_en = 1, parity_odd = 1, send 0x03 with parity bit 0 -> parity_err = 1; parity bit 1 -> parity_err = 0.
REQ-038 rx low for 4 bclk ticks then high -> no dout_valid, rx_busy returns 0 at false-start decision.
REQ-039 two_stop = 1, second stop bit driven 0 on 0x5A -> dout = 0x5A, frame_err = 1.
REQ-040 dout_ready held 0, send 0x11 then 0x22 -> dout stays 0x11, overrun pulses once; then ready 1 -> valid clears.
REQ-041 Single-tick glitch to 0 at cnt = M of a data bit (0xFF) -> majority keeps dout = 0xFF; rst mid-frame -> no output.
